mem_arbiter: RTL
================

# mem_arbiter

Single-port memory arbiter that shares one unified instruction/data memory between the fetch stage (instruction port) and the memory stage (data port) of the pipelined core. It serializes accesses, sequences the fixed-latency memory through a small FSM, and returns read data or a write acknowledge to the owner. It also generates the fetch and memory-stage stall signals the pipeline uses while an access is outstanding.

## Interface
- ADDR_W, 32, address width of both ports and the memory
- DATA_W, 32, data width
- MEM_LATENCY, 2, cycles from the command edge to valid mem_rdata; legal range ≥1
- MAX_D_STREAK, 4, consecutive data grants allowed while instruction is waiting (fairness only)

- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- i_req  in  1  instruction fetch request (read only)
- i_addr  in  ADDR_W  fetch address
- i_gnt  out  1  one-cycle grant pulse, instruction port
- i_rvalid  out  1  one-cycle pulse, i_rdata valid
- i_rdata  out  DATA_W  fetched word; held until next i_rvalid
- d_req  in  1  data request
- d_we  in  1  1=write, 0=read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_size  in  2  access size code (byte/half/word)
- d_unsigned  in  1  unsigned load
- d_gnt  out  1  one-cycle grant pulse, data port
- d_rvalid  out  1  one-cycle pulse: load data valid, or store complete
- d_rdata  out  DATA_W  load data; held until next load's d_rvalid
- mem_en  out  1  memory command strobe
- mem_we, mem_addr, mem_wdata, mem_size, mem_unsigned  out  1/ADDR_W/DATA_W/2/1  memory command fields
- mem_rdata  in  DATA_W  memory read data
- stall_F  out  1  fetch stall
- stall_M  out  1  memory-stage stall
- busy  out  1  FSM not in IDLE

## Operation
- FSM states: IDLE, WAIT, RESP. Owner register: 0=instr, 1=data.
- IDLE: if any request is pending, grant a winner. The grant is combinational in IDLE. In the same cycle: gnt pulse, mem_en=1, and the command fields are driven from the winner (instruction commands are forced to mem_we=0, word size, unsigned). Latch the owner, load the latency counter with MEM_LATENCY, and go to WAIT.
- WAIT: decrement the counter. On the edge where it reaches 0, sample mem_rdata into the owner's rdata register (reads only) and go to RESP.
- RESP: assert the owner's rvalid for one cycle, then go to IDLE. No grant is made in RESP.
- Priority: data wins over instruction, because the memory stage holds the older instruction.
- Streak counter (fairness): counts data grants made while i_req=1. It clears on any instruction grant, and on a data grant made with i_req=0. When the count equals MAX_D_STREAK and both ports request, the instruction port wins.
- Requesters hold req and the command fields stable from assertion until their rvalid, and drop req in the cycle after rvalid. If req drops after grant, the access still completes and rvalid is still pulsed.
- Writes: no rdata update; d_rvalid acts as the store acknowledge.
- stall_F = i_req & ~i_rvalid; stall_M = d_req & ~d_rvalid (combinational).
- Reset (asserted at any time, including mid-access): state=IDLE, counters=0, owner=0, all outputs 0, rdata registers 0. An in-flight access is abandoned with no rvalid.

## Timing
- Grant at cycle t (mem_en high in cycle t only), mem_rdata valid in cycle t+MEM_LATENCY, rvalid in cycle t+MEM_LATENCY+1.
- Throughput: one access per MEM_LATENCY+2 cycles under continuous requests.
- Simultaneous i_req and d_req in IDLE: exactly one gnt; the loser stays stalled and is granted at the next IDLE.
- A request arriving during WAIT or RESP waits for IDLE, and its stall is high throughout.

## Configuration
- MEM_ARB_FAIRNESS_EN defined: streak counter and MAX_D_STREAK override are compiled in.
- Not defined: strict data-over-instruction priority. No streak counter is built, and MAX_D_STREAK is ignored.

## Structure
- The shared package holds the access size codes (byte/half/word), the FSM state enum, and owner encodings. The memory's existing size constants are reused.
- One natural sub-module: mem_arb_pick, the combinational winner select plus streak counter.

## Test plan
- Lone fetch, MEM_LATENCY=2, i_addr=0x100, mem_rdata=0x00000013 → i_gnt at t, i_rvalid at t+3 with i_rdata=0x00000013; stall_F high t..t+2.
- Simultaneous i_req/d_req (load 0x200 → 0xDEADBEEF) → d_gnt first and d_rvalid at t+3; i_gnt at t+4 and i_rvalid at t+7.
- Store d_addr=0x40, d_wdata=0x12345678, d_size=word → mem_we=1 with matching fields at the grant cycle, d_rvalid at t+3, d_rdata unchanged.
- Fairness on, MAX_D_STREAK=4, d_req and i_req held high → grant sequence D,D,D,D,I,D…; with the macro off → D indefinitely, I never granted.
- reset asserted during WAIT → all outputs 0 immediately, no rvalid; after release, a held request is re-granted at the first IDLE cycle.
- MEM_LATENCY=1 back-to-back fetches → grants every 3 cycles, i_rvalid 2 cycles after each grant.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified-memory arbiter: access size codes,
// arbiter FSM states, port-owner encodings and a counter-width helper.
package mem_arbiter_pkg;

  localparam int unsigned SIZE_W = 2;

  // Access size codes understood by the memory
  typedef enum logic [SIZE_W-1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_e;

  // Bits needed for a counter spanning 0..max_val (at least one bit)
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select for the shared memory port. Data beats instruction; with
// MEM_ARB_FAIRNESS_EN defined, a streak counter lets a waiting fetch in
// after MAX_D_STREAK consecutive data grants.
module mem_arb_pick
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en_i,
  input  logic   i_req_i,
  input  logic   d_req_i,
  output logic   gnt_c_o,
  output owner_e win_c_o
);

  localparam int unsigned STREAK_W = cnt_width(MAX_D_STREAK);

  assign gnt_c_o = en_i & (i_req_i | d_req_i);

`ifdef MEM_ARB_FAIRNESS_EN
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                at_limit;

  assign at_limit = (streak_q == STREAK_W'(MAX_D_STREAK));

  // Data wins unless it has already starved a waiting fetch long enough
  always_comb begin
    win_c_o = d_req_i ? OWNER_D : OWNER_I;
    if (i_req_i && d_req_i && at_limit) win_c_o = OWNER_I;
  end

  // Count data grants taken while the fetch port was waiting
  always_comb begin
    streak_d = streak_q;
    if (gnt_c_o) begin
      if (win_c_o == OWNER_D && i_req_i) streak_d = streak_q + STREAK_W'(1);
      else                               streak_d = '0;
    end
  end

  // Streak register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) streak_q <= '0;
    else        streak_q <= streak_d;
  end
`else
  logic [STREAK_W-1:0] unused_streak_max;
  logic                unused_clk_rst;

  assign unused_streak_max = STREAK_W'(MAX_D_STREAK);
  assign unused_clk_rst    = clk ^ rst_n;
  assign win_c_o           = d_req_i ? OWNER_D : OWNER_I;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter sharing one unified memory between the fetch
// (instruction) and memory-stage (data) ports. Grants are combinational in
// IDLE, the access then waits MEM_LATENCY cycles and the owner sees a
// one-cycle rvalid. Optional fetch fairness: define MEM_ARB_FAIRNESS_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MEM_LATENCY  = 2,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic              i_gnt_c_o,
  output logic              i_rvalid_o,
  output logic [DATA_W-1:0] i_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  input  logic [SIZE_W-1:0] d_size_i,
  input  logic              d_unsigned_i,
  output logic              d_gnt_c_o,
  output logic              d_rvalid_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              mem_en_c_o,
  output logic              mem_we_c_o,
  output logic [ADDR_W-1:0] mem_addr_c_o,
  output logic [DATA_W-1:0] mem_wdata_c_o,
  output logic [SIZE_W-1:0] mem_size_c_o,
  output logic              mem_unsigned_c_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_f_c_o,
  output logic              stall_m_c_o,
  output logic              busy_o
);

  localparam int unsigned CNT_W = cnt_width(MEM_LATENCY);

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  owner_e              win_c;
  logic                we_q, we_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                i_rvalid_q, i_rvalid_d;
  logic                d_rvalid_q, d_rvalid_d;
  logic                busy_q, busy_d;
  logic                idle_c;
  logic                gnt_c;

  // Grants only happen in IDLE and never while reset is held
  assign idle_c = rst_n & (state_q == ST_IDLE);

  mem_arb_pick #(
    .MAX_D_STREAK (MAX_D_STREAK)
  ) u_pick (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (idle_c),
    .i_req_i (i_req_i),
    .d_req_i (d_req_i),
    .gnt_c_o (gnt_c),
    .win_c_o (win_c)
  );

  // Grant pulse and memory command driven from the winner in the grant cycle
  always_comb begin
    i_gnt_c_o        = 1'b0;
    d_gnt_c_o        = 1'b0;
    mem_en_c_o       = 1'b0;
    mem_we_c_o       = 1'b0;
    mem_addr_c_o     = '0;
    mem_wdata_c_o    = '0;
    mem_size_c_o     = '0;
    mem_unsigned_c_o = 1'b0;
    if (gnt_c) begin
      mem_en_c_o = 1'b1;
      if (win_c == OWNER_D) begin
        d_gnt_c_o        = 1'b1;
        mem_we_c_o       = d_we_i;
        mem_addr_c_o     = d_addr_i;
        mem_wdata_c_o    = d_wdata_i;
        mem_size_c_o     = d_size_i;
        mem_unsigned_c_o = d_unsigned_i;
      end else begin
        i_gnt_c_o        = 1'b1;
        mem_addr_c_o     = i_addr_i;
        mem_size_c_o     = SIZE_WORD;
        mem_unsigned_c_o = 1'b1;
      end
    end
  end

  // Access sequencing: grant, count down the memory latency, respond
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    cnt_d      = cnt_q;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    i_rvalid_d = 1'b0;
    d_rvalid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_c) begin
          owner_d = win_c;
          we_d    = (win_c == OWNER_D) & d_we_i;
          cnt_d   = CNT_W'(MEM_LATENCY);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_RESP;
          if (owner_q == OWNER_I) begin
            i_rdata_d  = mem_rdata_i;
            i_rvalid_d = 1'b1;
          end else begin
            if (!we_q) d_rdata_d = mem_rdata_i;
            d_rvalid_d = 1'b1;
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs; reset abandons any in-flight access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWNER_I;
      we_q       <= 1'b0;
      cnt_q      <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      cnt_q      <= cnt_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
      i_rvalid_q <= i_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
      busy_q     <= busy_d;
    end
  end

  assign i_rvalid_o  = i_rvalid_q;
  assign d_rvalid_o  = d_rvalid_q;
  assign i_rdata_o   = i_rdata_q;
  assign d_rdata_o   = d_rdata_q;
  assign busy_o      = busy_q;
  assign stall_f_c_o = rst_n & i_req_i & ~i_rvalid_q;
  assign stall_m_c_o = rst_n & d_req_i & ~d_rvalid_q;

endmodule
